// File: rtl/input_operation_encoder.sv
// Button front end for the tetrimino game: synchronise, debounce and arbitrate the player buttons
// into one operation code per video frame. Define INPUT_AUTOREPEAT_EN to build the auto-repeat FSMs.
module input_operation_encoder #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 12,
    parameter int REPEAT_RATE     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vsync,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_rotate,
    input  logic       btn_drop,
    input  logic       btn_start,
    output logic [2:0] operation,
    output logic [9:0] framenumber
);
    localparam int NB = 5;
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DB_LIMIT = CW'(DEBOUNCE_CYCLES);

    localparam int B_LEFT   = 0;
    localparam int B_RIGHT  = 1;
    localparam int B_ROTATE = 2;
    localparam int B_DROP   = 3;
    localparam int B_START  = 4;

    localparam logic [2:0] OP_NONE   = 3'd0;
    localparam logic [2:0] OP_LEFT   = 3'd1;
    localparam logic [2:0] OP_RIGHT  = 3'd2;
    localparam logic [2:0] OP_ROTATE = 3'd3;
    localparam logic [2:0] OP_START  = 3'd4;
    localparam logic [2:0] OP_DROP   = 3'd5;

    logic [NB-1:0] w_btn_raw;
    logic [NB-1:0] r_btn_meta;
    logic [NB-1:0] r_btn_sync;
    logic [NB-1:0] w_btn_deb;
    logic [NB-1:0] r_btn_deb_d;
    logic [NB-1:0] w_press;
    logic [NB-1:0] w_repeat;
    logic [NB-1:0] w_event;
    logic          r_vs_meta;
    logic          r_vs_sync;
    logic          r_vs_d;
    logic          r_tick;
    logic [2:0]    w_event_code;
    logic [2:0]    r_pending;
    logic [2:0]    r_operation;
    logic [9:0]    r_framenumber;

    assign w_btn_raw = {btn_start, btn_drop, btn_rotate, btn_right, btn_left};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_btn_meta  <= '0;
            r_btn_sync  <= '0;
            r_btn_deb_d <= '0;
            r_vs_meta   <= 1'b0;
            r_vs_sync   <= 1'b0;
            r_vs_d      <= 1'b0;
            r_tick      <= 1'b0;
        end else begin
            r_btn_meta  <= w_btn_raw;
            r_btn_sync  <= r_btn_meta;
            r_btn_deb_d <= w_btn_deb;
            r_vs_meta   <= vsync;
            r_vs_sync   <= r_vs_meta;
            r_vs_d      <= r_vs_sync;
            r_tick      <= r_vs_sync & ~r_vs_d;
        end
    end

    // The debounced level only moves once the synchronised level has disagreed with it
    // for DEBOUNCE_CYCLES+1 consecutive samples; any agreement restarts the count.
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_debounce
            logic [CW-1:0] r_db_cnt;
            logic          r_deb;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_db_cnt <= '0;
                    r_deb    <= 1'b0;
                end else if (r_btn_sync[gi] == r_deb) begin
                    r_db_cnt <= '0;
                end else if (r_db_cnt == DB_LIMIT) begin
                    r_deb    <= r_btn_sync[gi];
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end

            assign w_btn_deb[gi] = r_deb;
        end
    endgenerate

    assign w_press = w_btn_deb & ~r_btn_deb_d;

`ifdef INPUT_AUTOREPEAT_EN
    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_DELAY,
        RPT_REPEAT
    } rpt_state_t;

    localparam logic [5:0] DELAY_LIMIT = 6'(REPEAT_DELAY);
    localparam logic [5:0] RATE_LIMIT  = 6'(REPEAT_RATE);

    generate
        for (gi = 0; gi < NB; gi++) begin : g_repeat
            if (gi == B_LEFT || gi == B_RIGHT || gi == B_DROP) begin : g_fsm
                rpt_state_t r_state;
                logic [5:0] r_cnt;
                logic [5:0] w_cnt_inc;

                assign w_cnt_inc = r_cnt + 6'd1;
                // Injected in the tick cycle itself, so the repeat lands in the next frame's pending slot.
                assign w_repeat[gi] = r_tick && w_btn_deb[gi] &&
                                      ((r_state == RPT_DELAY  && w_cnt_inc == DELAY_LIMIT) ||
                                       (r_state == RPT_REPEAT && w_cnt_inc == RATE_LIMIT));

                always_ff @(posedge clk) begin
                    if (reset || !w_btn_deb[gi]) begin
                        r_state <= RPT_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        case (r_state)
                            RPT_IDLE: begin
                                if (w_press[gi]) begin
                                    r_state <= RPT_DELAY;
                                    r_cnt   <= '0;
                                end
                            end
                            RPT_DELAY: begin
                                if (r_tick) begin
                                    if (w_cnt_inc == DELAY_LIMIT) begin
                                        r_state <= RPT_REPEAT;
                                        r_cnt   <= '0;
                                    end else begin
                                        r_cnt <= w_cnt_inc;
                                    end
                                end
                            end
                            RPT_REPEAT: begin
                                if (r_tick) begin
                                    r_cnt <= (w_cnt_inc == RATE_LIMIT) ? 6'd0 : w_cnt_inc;
                                end
                            end
                            default: begin
                                r_state <= RPT_IDLE;
                                r_cnt   <= '0;
                            end
                        endcase
                    end
                end
            end else begin : g_no_fsm
                assign w_repeat[gi] = 1'b0;
            end
        end
    endgenerate
`else
    assign w_repeat = '0;

    // Repeat timing has no effect in this build; the parameters stay so both builds share one interface.
    generate
        if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_repeat_params_unused
        end
    endgenerate
`endif

    assign w_event = w_press | w_repeat;

    always_comb begin
        w_event_code = OP_NONE;
        if (w_event[B_START]) begin
            w_event_code = OP_START;
        end else if (w_event[B_ROTATE]) begin
            w_event_code = OP_ROTATE;
        end else if (w_event[B_LEFT]) begin
            w_event_code = OP_LEFT;
        end else if (w_event[B_RIGHT]) begin
            w_event_code = OP_RIGHT;
        end else if (w_event[B_DROP]) begin
            w_event_code = OP_DROP;
        end
    end

    // On a tick the slot is emptied and refilled by the same cycle's event, so nothing is lost or merged.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending     <= OP_NONE;
            r_operation   <= OP_NONE;
            r_framenumber <= '0;
        end else if (r_tick) begin
            r_operation   <= r_pending;
            r_framenumber <= r_framenumber + 10'd1;
            r_pending     <= w_event_code;
        end else if (r_pending == OP_NONE) begin
            r_pending <= w_event_code;
        end
    end

    assign operation   = r_operation;
    assign framenumber = r_framenumber;

endmodule

// File: tb/tb_input_operation_encoder.sv
// Frame-level bench for input_operation_encoder: directed scenarios plus randomized presses
// checked against a first-come / fixed-priority model of the command arbitration.
module tb_input_operation_encoder;
    localparam int DEB = 4;
    localparam int RD  = 3;
    localparam int RR  = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       vsync;
    logic       btn_left;
    logic       btn_right;
    logic       btn_rotate;
    logic       btn_drop;
    logic       btn_start;
    logic [2:0] operation;
    logic [9:0] framenumber;

    int checks = 0;
    int errors = 0;
    int exp_fn = 0;
    // Per-frame button schedule, index 0 left, 1 right, 2 rotate, 3 drop, 4 start.
    int st[5];
    int en[5];
    logic [4:0] hold_mask;

    always #5 clk = ~clk;

    input_operation_encoder #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .vsync      (vsync),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_rotate (btn_rotate),
        .btn_drop   (btn_drop),
        .btn_start  (btn_start),
        .operation  (operation),
        .framenumber(framenumber)
    );

    task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic logic [2:0] code_of(input int b);
        case (b)
            0:       return 3'd1;
            1:       return 3'd2;
            2:       return 3'd3;
            3:       return 3'd5;
            default: return 3'd4;
        endcase
    endfunction

    // Earliest press wins; equal times fall back to start > rotate > left > right > drop.
    function automatic logic [2:0] first_come(input logic [4:0] mask, input int t[5]);
        int order[5];
        int best_t;
        logic [2:0] best;
        order[0] = 4; order[1] = 2; order[2] = 0; order[3] = 1; order[4] = 3;
        best_t = 1000000;
        best   = 3'd0;
        for (int k = 0; k < 5; k++) begin
            if (mask[order[k]] && t[order[k]] < best_t) begin
                best_t = t[order[k]];
                best   = code_of(order[k]);
            end
        end
        return best;
    endfunction

    task automatic clear_sched();
        for (int b = 0; b < 5; b++) begin
            st[b] = -1;
            en[b] = -1;
        end
    endtask

    task automatic drive_buttons(input int p);
        logic [4:0] lvl;
        for (int b = 0; b < 5; b++) begin
            lvl[b] = hold_mask[b] || (p >= st[b] && p < en[b]);
        end
        btn_left   = lvl[0];
        btn_right  = lvl[1];
        btn_rotate = lvl[2];
        btn_drop   = lvl[3];
        btn_start  = lvl[4];
    endtask

    // One frame: vsync rises at phase 0 and stays high 5 cycles; outputs are checked mid-frame.
    task automatic frame(input int len, input logic [2:0] exp_op, input string tag);
        exp_fn = (exp_fn + 1) % 1024;
        for (int p = 0; p < len; p++) begin
            @(negedge clk);
            if (p == len / 2) begin
                check({tag, " operation"}, {7'd0, operation}, {7'd0, exp_op});
                check({tag, " framenumber"}, framenumber, exp_fn[9:0]);
                $display("frame %s: operation=%0d framenumber=%0d", tag, operation, framenumber);
            end
            vsync = (p < 5);
            drive_buttons(p);
        end
    endtask

    initial begin
        logic [2:0] exp_op;
        logic [2:0] prev_op;
        logic [2:0] cur_op;
        logic [4:0] mask;
        int g;

        reset      = 1'b1;
        vsync      = 1'b0;
        hold_mask  = 5'h1f;
        clear_sched();
        drive_buttons(0);
        repeat (3) @(negedge clk);
        check("reset operation", {7'd0, operation}, 10'd0);
        check("reset framenumber", framenumber, 10'd0);
        $display("reset: operation=%0d framenumber=%0d", operation, framenumber);
        reset  = 1'b0;
        exp_fn = 0;

        // All buttons held through reset become press events together.
        hold_mask = 5'h00;
        for (int b = 0; b < 5; b++) begin
            st[b] = 0;
            en[b] = 40;
        end
        frame(100, 3'd0, "post_reset");
        clear_sched();
        frame(100, 3'd4, "reset_priority");

        st[0] = 20; en[0] = 50;
        st[1] = 60; en[1] = 63;
        frame(100, 3'd0, "single_press");
        clear_sched();
        frame(100, 3'd1, "single_left");
        frame(100, 3'd0, "single_clear");

        st[2] = 20; en[2] = 40;
        st[0] = 20; en[0] = 40;
        frame(100, 3'd0, "same_cycle");
        clear_sched();
        st[3] = 10; en[3] = 30;
        st[4] = 40; en[4] = 60;
        frame(100, 3'd3, "rotate_over_left");
        clear_sched();
        frame(100, 3'd5, "drop_first");
        frame(100, 3'd0, "start_dropped");

        // Raw edge at phase 96 debounces exactly in the tick cycle of the next frame.
        st[0] = 96; en[0] = 100;
        frame(100, 3'd0, "collision_pre");
        clear_sched();
        st[0] = 0; en[0] = 30;
        frame(100, 3'd0, "collision_tick");
        clear_sched();
        frame(100, 3'd1, "collision_next");
        frame(100, 3'd0, "collision_clear");

        st[1] = 20; en[1] = 100;
        frame(100, 3'd0, "repeat_press");
        clear_sched();
        for (int i = 0; i < 10; i++) begin
            exp_op = (i == 0) ? 3'd2 : 3'd0;
`ifdef INPUT_AUTOREPEAT_EN
            if (i >= RD && (i - RD) % RR == 0) exp_op = 3'd2;
`endif
            if (i < 9) begin
                hold_mask = 5'b00010;
            end else begin
                hold_mask = 5'b00000;
                st[1] = 0;
                en[1] = 20;
            end
            frame(100, exp_op, "repeat");
        end
        clear_sched();
        frame(100, 3'd0, "repeat_release");

        prev_op = 3'd0;
        for (int f = 0; f < 20; f++) begin
            clear_sched();
            mask = 5'($urandom_range(31, 0));
            for (int b = 0; b < 5; b++) begin
                if (mask[b]) begin
                    st[b] = 10 * int'($urandom_range(3, 1));
                    en[b] = st[b] + 20;
                end
            end
            g = int'($urandom_range(4, 0));
            if (!mask[g]) begin
                st[g] = 60;
                en[g] = 60 + int'($urandom_range(3, 1));
            end
            cur_op = first_come(mask, st);
            frame(100, prev_op, "random");
            prev_op = cur_op;
        end
        clear_sched();
        frame(100, prev_op, "random_tail");

        // Short frames to walk framenumber through 1023 -> 0.
        for (int f = 0; f < 1030; f++) begin
            frame(20, 3'd0, "wrap");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/input_operation_encoder.md
# input_operation_encoder

Upstream front end of the tetrimino game logic. Synchronises and debounces the raw player buttons and arbitrates them into one 3-bit `operation` command per video frame. Holds that command stable across the whole next frame so the game logic can sample it safely on its `posedge vsync`. Also supplies the free-running `framenumber` counter that the game logic consumes.

## Interface
- `DEBOUNCE_CYCLES`, 50000: number of consecutive `clk` cycles a synchronised button level must differ from its debounced state before that state flips.
- `REPEAT_DELAY`, 12: frames a repeatable button must be held before the first auto-repeat.
- `REPEAT_RATE`, 4: frames between subsequent auto-repeats.
- `clk  in  1`: system clock. The only clock.
- `reset  in  1`: synchronous reset, active-high.
- `vsync  in  1`: frame strobe from the VGA timing block. Asynchronous to this block's logic; 2-flop synchronised, rising edge detected.
- `btn_left`, `btn_right`, `btn_rotate`, `btn_drop`, `btn_start`  `in  1` each: raw active-high buttons, asynchronous.
- `operation  out  3`: command code.
  - 0 = none, 1 = left, 2 = right, 3 = rotate, 4 = start, 5 = drop.
  - 6 and 7 are never driven.
- `framenumber  out  10`: frame counter.

## Operation
- **Input path, per button:**
  - 2-flop synchroniser.
  - Debouncer: counter of width clog2(`DEBOUNCE_CYCLES`+1). It resets to 0 whenever the synchronised level equals the debounced level.
  - When the counter reaches `DEBOUNCE_CYCLES`, the debounced level flips and the counter clears.
  - A 0→1 transition of the debounced level is a press event, one `clk` wide.
- **Frame tick:** single-cycle `tick`, asserted the cycle after the synchronised `vsync` goes 0→1.
- **Pending register:** 3 bits, 0 = empty.
  - A press event loads it only when it is empty (first-come wins).
  - Same-cycle events are resolved by fixed priority: start > rotate > left > right > drop.
- **On `tick`:**
  - `operation <= pending`.
  - `framenumber <= framenumber + 1`, 10-bit wrap 1023→0.
  - Pending is cleared, then immediately reloaded by any event in that same cycle. Such an event therefore goes to the following frame; it is never lost and never merged.
- **No new command in a frame:** `operation` becomes 0 at the next `tick`. Every non-zero code is presented for exactly one frame period.
- **Auto-repeat:** left, right and drop only. Per-button FSM with states IDLE, DELAY, REPEAT and a 6-bit frame counter.
  - IDLE→DELAY on press event; counter = 0.
  - DELAY: counter +1 per `tick`. At `REPEAT_DELAY` → REPEAT, inject a repeat event, counter = 0.
  - REPEAT: counter +1 per `tick`. At `REPEAT_RATE`, inject a repeat event, counter = 0.
  - Any state → IDLE when the debounced level is 0.
  - Repeat events arbitrate exactly like press events.
- **Never repeat:** start and rotate.

## Timing
- **Reset values:** `operation` = 0, `framenumber` = 0, pending = 0. All debounced levels 0, all debounce counters 0, all repeat FSMs IDLE, synchroniser flops 0.
- **Reset mid-operation:** pending command and repeat state are discarded. A button held through reset produces a fresh press event once debounced after reset release.
- **Latency, raw button edge → debounced event:** 2 + `DEBOUNCE_CYCLES` + 1 cycles.
- **Latency, raw `vsync` rise → `tick`:** 3 cycles.
- **`operation` update timing:** `operation` changes only in the cycle after `tick`. The game logic samples it at the following `vsync` rise, so command-to-consumer latency is one frame.
- **Minimum `vsync` high time:** 3 `clk` cycles, so that no tick is missed. Documented constraint, not checked by this block.
- **Simultaneous `tick` and event:** handled as described under Operation; the event lands in the next frame's pending register.
- **Bounce shorter than `DEBOUNCE_CYCLES`:** no event.

## Configuration
- `INPUT_AUTOREPEAT_EN` defined: repeat FSMs and their counters are compiled in; behaviour as above.
- `INPUT_AUTOREPEAT_EN` undefined: repeat logic is absent. Every command requires a fresh press, and `REPEAT_DELAY` / `REPEAT_RATE` are ignored.

## Test plan
The bench uses `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=3, `REPEAT_RATE`=2, `vsync` period 100 `clk`, high 5 `clk`.

- **Reset:** assert `reset` 3 cycles with all buttons high → `operation`=0 and `framenumber`=0 during reset. After reset release, all five buttons are seen as press events once debounced; priority gives `operation`=4 after the next tick.
- **Single press:** `btn_left` high for 30 cycles mid-frame → `operation`=1 for exactly one frame, then 0. A 3-cycle glitch on `btn_right` → no command.
- **Arbitration:**
  - `btn_rotate` and `btn_left` rise in the same cycle → 3.
  - `btn_drop` pressed, then `btn_start` later in the same frame → 5 (first-come), with `btn_start` dropped.
- **Tick collision:** a left press event aligned with the `tick` cycle → `operation`=0 this frame and 1 in the following frame.
- **Auto-repeat** (macro defined): hold `btn_right` for 10 frames → `operation` sequence 2,0,0,2,0,2,0,2,0,2. With the macro undefined → 2 then nine 0s.
- **Wrap:** run 1024 frames → `framenumber` goes 1023→0 with no gap.
